track_ctrl: RTL and testbench
=============================

Name: track_ctrl

Overview:
- Frame-level controller downstream of the red-group detector (row/col centroid plus presence flag, once per 640x480 frame).
- Edge-detects the detector's frame-boundary strobe and samples one coordinate per frame.
- Runs an acquire/track/coast/lost state machine with jump rejection and shift-based smoothing.
- Publishes a filtered cursor coordinate to the game/CPU side over a valid/ready handshake.

Parameters:
- ACQ_FRAMES, 3: consecutive consistent hits needed to enter TRACK (1..15).
- LOSE_FRAMES, 4: consecutive misses in COAST before declaring lost (1..15).
- MAX_JUMP, 64: max per-axis |delta| in pixels between frames still counted as the same target.
- SMOOTH_SHIFT, 2: IIR smoothing shift k, where filt += (sample - filt) >>> k (0..4; 0 = no smoothing).

Ports:
- iCLK  in  1  pixel/system clock
- iRST  in  1  asynchronous active-low reset
- iEnable  in  1  tracking enable; low forces DISABLED
- iRow  in  11  detector row centroid
- iCol  in  11  detector column centroid
- iCoordValid  in  1  detector frame-boundary strobe (level, may stay high several cycles)
- iPresent  in  1  detector target-present flag
- oRow  out  11  published filtered row
- oCol  out  11  published filtered column
- oValid  out  1  published coordinate pending
- iReady  in  1  consumer accepts when oValid & iReady
- oTracking  out  1  high in TRACK or COAST
- oLost  out  1  one-cycle pulse on COAST->SEARCH

Behaviour:
- Reset: all outputs 0, state DISABLED, counters 0, filt 0, cv_q 0.
- Frame event: iCoordValid & !cv_q, where cv_q is iCoordValid registered. Exactly one event per strobe regardless of its length.
- On the event cycle, latch iRow, iCol and hit. hit = iPresent & (iRow <= 479) & (iCol <= 639); out-of-range counts as a miss.
- FSM evaluates the latched sample one cycle after the event (E+1).
- oRow/oCol/oValid update at E+2.
- States: DISABLED, SEARCH, ACQUIRE, TRACK, COAST.
- DISABLED: iEnable=1 -> SEARCH.
- iEnable=0 in any state -> DISABLED next cycle. Also clears counters, oValid and oTracking, and drops any pending coordinate. Has priority over a simultaneous frame event.
- SEARCH: on hit -> ACQUIRE, hit_cnt=1, ref=sample.
- ACQUIRE, hit within MAX_JUMP of ref on both axes:
  - hit_cnt+1 and ref=sample.
  - When hit_cnt reaches ACQ_FRAMES -> TRACK, filt=sample unfiltered, publish.
  - If ACQ_FRAMES=1, SEARCH goes directly to TRACK.
- ACQUIRE, hit outside MAX_JUMP: stay ACQUIRE, hit_cnt=1, ref=sample.
- ACQUIRE, miss: -> SEARCH, hit_cnt=0.
- TRACK/COAST, hit within MAX_JUMP of filt:
  - filt update, miss_cnt=0, -> TRACK, publish.
  - Arithmetic: 12-bit signed diff, arithmetic shift, result clamped to 0..639 / 0..479.
- TRACK/COAST, jump or miss: miss_cnt+1, -> COAST, republish held filt.
  - When miss_cnt reaches LOSE_FRAMES -> SEARCH, oLost=1 for one cycle, no publish.
- Handshake:
  - Publish sets oValid=1 and loads oRow/oCol.
  - oValid & iReady clears oValid next cycle unless a publish occurs that same cycle; publish wins and oValid stays 1 with new data.
  - Publish while oValid=1 and iReady=0 overwrites data (latest wins), oValid stays 1.
  - Data is stable between publishes.
- oTracking is registered and reflects the state at E+2 granularity.
- Reset mid-frame: everything clears. The next strobe edge after reset is a valid event even if iCoordValid is already high at reset release, because cv_q resets to 0.

Optional Feature:
- Macro TRACK_DROP_COUNT_EN.
- Defined:
  - Adds output oDropCount (8 bits) and input iDropClr (1 bit).
  - oDropCount counts publishes that overwrote an unaccepted coordinate; it saturates at 255.
  - iDropClr clears it synchronously; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package track_ctrl_pkg:
  - state enum (DISABLED, SEARCH, ACQUIRE, TRACK, COAST).
  - FRAME_W=640, FRAME_H=480, COORD_W=11.
  - Max-index constants 639 and 479.
- Sub-module coord_smooth:
  - Combinational per-axis filt/sample -> abs-delta compare and shifted, clamped update.
  - Instantiated twice (row and col), parameterised by axis max and SMOOTH_SHIFT.

Test Plan:
- Strobe held 5 cycles with iPresent=1 at (100,200), iReady=1, three frames -> exactly one event per frame; TRACK entered on frame 3; oValid pulses with (100,200) at E+2 of frame 3.
- In TRACK at filt (100,200), next sample (140,200) with k=2 -> oRow=110, oCol=200; sample (300,200) (jump 190) -> COAST, republishes (110,200).
- Four consecutive misses after TRACK with LOSE_FRAMES=4 -> COAST on misses 1-3, SEARCH plus a single-cycle oLost on miss 4, oTracking falls, no 4th publish.
- iReady=0 across two TRACK frames (hits at (50,60) then (50,60)) -> oValid stays 1, data = latest, oDropCount=1 with the macro; iReady=1 -> oValid drops next cycle.
- iEnable deasserted on the same cycle as a frame event while in TRACK with oValid=1 -> next cycle DISABLED, oValid=0, oTracking=0, no publish.
- Out-of-range sample iRow=500 with iPresent=1 in ACQUIRE -> treated as a miss, back to SEARCH; iRST low mid-ACQUIRE -> all outputs 0 immediately.

Source files
------------

// File: rtl/track_ctrl_pkg.sv
// track_ctrl_pkg: shared frame geometry, coordinate width and FSM state encoding
package track_ctrl_pkg;
  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(FRAME_H - 1);
  typedef enum logic [2:0] {S_DISABLED, S_SEARCH, S_ACQUIRE, S_TRACK, S_COAST} state_t;
endpackage

// File: rtl/track_ctrl_coord_smooth.sv
// coord_smooth: per-axis jump check and shift-based IIR update clamped to the axis range
module coord_smooth
  import track_ctrl_pkg::*;
#(
  parameter logic [COORD_W-1:0] AXIS_MAX = COL_MAX,
  parameter int SMOOTH_SHIFT = 2,
  parameter int MAX_JUMP = 64
) (
  input  logic [COORD_W-1:0] filt,
  input  logic [COORD_W-1:0] sample,
  output logic               near,
  output logic [COORD_W-1:0] upd
);
  logic signed [11:0] diff;
  logic signed [11:0] step;
  logic [11:0] mag;
  logic signed [12:0] sum;
  // signed delta, magnitude compare, arithmetic-shift step and clamp
  always_comb begin
    diff = {1'b0, sample} - {1'b0, filt};
    mag = diff[11] ? -diff : diff;
    near = mag <= 12'(MAX_JUMP);
    step = diff >>> SMOOTH_SHIFT;
    sum = {2'b00, filt} + {step[11], step};
    upd = sum[12] ? '0 : (sum[11:0] > {1'b0, AXIS_MAX}) ? AXIS_MAX : sum[10:0];
  end
endmodule

// File: rtl/track_ctrl.sv
// track_ctrl: frame-level acquire/track/coast controller publishing a smoothed cursor
// over valid/ready; TRACK_DROP_COUNT_EN adds an overwrite (drop) counter.
module track_ctrl
  import track_ctrl_pkg::*;
#(
  parameter int ACQ_FRAMES = 3,
  parameter int LOSE_FRAMES = 4,
  parameter int MAX_JUMP = 64,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iEnable,
  input  logic [COORD_W-1:0] iRow,
  input  logic [COORD_W-1:0] iCol,
  input  logic               iCoordValid,
  input  logic               iPresent,
  output logic [COORD_W-1:0] oRow,
  output logic [COORD_W-1:0] oCol,
  output logic               oValid,
  input  logic               iReady,
  output logic               oTracking,
`ifdef TRACK_DROP_COUNT_EN
  output logic [7:0]         oDropCount,
  input  logic               iDropClr,
`endif
  output logic               oLost
);
  state_t state_q, state_d;
  logic cv_q, cv_d, evt_q, evt_d, hit_q, hit_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [COORD_W-1:0] filt_row_q, filt_row_d, filt_col_q, filt_col_d;
  logic [COORD_W-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [3:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic valid_q, valid_d, track_q, track_d, lost_q, lost_d;
  logic evt, pub, near_r, near_c, near;
  logic [COORD_W-1:0] upd_r, upd_c;

  // filt doubles as the acquisition reference while in ACQUIRE
  coord_smooth #(.AXIS_MAX(ROW_MAX), .SMOOTH_SHIFT(SMOOTH_SHIFT), .MAX_JUMP(MAX_JUMP)) u_row (
    .filt(filt_row_q), .sample(row_q), .near(near_r), .upd(upd_r));
  coord_smooth #(.AXIS_MAX(COL_MAX), .SMOOTH_SHIFT(SMOOTH_SHIFT), .MAX_JUMP(MAX_JUMP)) u_col (
    .filt(filt_col_q), .sample(col_q), .near(near_c), .upd(upd_c));

  // frame-strobe edge detect and sample latch; disabled events are never seen by the FSM
  always_comb begin
    evt = iCoordValid & ~cv_q;
    cv_d = iCoordValid;
    evt_d = evt & iEnable;
    row_d = evt ? iRow : row_q;
    col_d = evt ? iCol : col_q;
    hit_d = evt ? (iPresent & (iRow <= ROW_MAX) & (iCol <= COL_MAX)) : hit_q;
    near = near_r & near_c;
  end

  // next-state logic: FSM decisions on the latched sample one cycle after the event
  always_comb begin
    state_d = state_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    filt_row_d = filt_row_q;
    filt_col_d = filt_col_q;
    pub = 1'b0;
    lost_d = 1'b0;
    if (!iEnable) begin
      state_d = S_DISABLED;
      hit_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      case (state_q)
        S_DISABLED: state_d = S_SEARCH;
        S_SEARCH: if (evt_q && hit_q) begin
          filt_row_d = row_q;
          filt_col_d = col_q;
          hit_cnt_d = 4'd1;
          miss_cnt_d = '0;
          state_d = (ACQ_FRAMES == 1) ? S_TRACK : S_ACQUIRE;
          pub = (ACQ_FRAMES == 1);
        end
        S_ACQUIRE: if (evt_q) begin
          if (!hit_q) begin
            state_d = S_SEARCH;
            hit_cnt_d = '0;
          end else begin
            filt_row_d = row_q;
            filt_col_d = col_q;
            hit_cnt_d = near ? hit_cnt_q + 4'd1 : 4'd1;
            if (near && (hit_cnt_q + 4'd1 >= 4'(ACQ_FRAMES))) begin
              state_d = S_TRACK;
              miss_cnt_d = '0;
              pub = 1'b1;
            end
          end
        end
        S_TRACK, S_COAST: if (evt_q) begin
          if (hit_q && near) begin
            filt_row_d = upd_r;
            filt_col_d = upd_c;
            miss_cnt_d = '0;
            state_d = S_TRACK;
            pub = 1'b1;
          end else if (miss_cnt_q + 4'd1 >= 4'(LOSE_FRAMES)) begin
            state_d = S_SEARCH;
            miss_cnt_d = '0;
            hit_cnt_d = '0;
            lost_d = 1'b1;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
            state_d = S_COAST;
            pub = 1'b1;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end
  end

  // output handshake: a publish always wins over acceptance and overwrites pending data
  always_comb begin
    track_d = (state_d == S_TRACK) || (state_d == S_COAST);
    valid_d = iEnable & (pub | (valid_q & ~iReady));
    orow_d = pub ? filt_row_d : orow_q;
    ocol_d = pub ? filt_col_d : ocol_q;
  end

`ifdef TRACK_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;
  // saturating count of publishes that replaced an unaccepted coordinate; clear wins
  always_comb begin
    drop_d = iDropClr ? 8'd0 : (pub & valid_q & ~iReady & (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end
  // drop counter register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign oDropCount = drop_q;
`endif

  // state, sample and output registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= S_DISABLED;
      cv_q <= 1'b0;
      evt_q <= 1'b0;
      hit_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      filt_row_q <= '0;
      filt_col_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      valid_q <= 1'b0;
      track_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cv_q <= cv_d;
      evt_q <= evt_d;
      hit_q <= hit_d;
      row_q <= row_d;
      col_q <= col_d;
      filt_row_q <= filt_row_d;
      filt_col_q <= filt_col_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      valid_q <= valid_d;
      track_q <= track_d;
      lost_q <= lost_d;
    end
  end

  assign oRow = orow_q;
  assign oCol = ocol_q;
  assign oValid = valid_q;
  assign oTracking = track_q;
  assign oLost = lost_q;
endmodule

// File: tb/tb_track_ctrl.sv
// tb_track_ctrl: directed self-checking bench for track_ctrl (ACQ=3, LOSE=4, JUMP=64, k=2)
module tb_track_ctrl;
  logic iCLK = 1'b0, iRST = 1'b0, iEnable = 1'b1, iCoordValid = 1'b0, iPresent = 1'b0, iReady = 1'b1;
  logic [10:0] iRow = '0, iCol = '0, oRow, oCol;
  logic oValid, oTracking, oLost;
  logic [7:0] drop;
  logic dclr = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic v2, t2, l2, v3, l3;
  logic [10:0] r2, c2;

  track_ctrl dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iRow(iRow), .iCol(iCol),
    .iCoordValid(iCoordValid), .iPresent(iPresent), .oRow(oRow), .oCol(oCol),
    .oValid(oValid), .iReady(iReady), .oTracking(oTracking),
`ifdef TRACK_DROP_COUNT_EN
    .oDropCount(drop), .iDropClr(dclr),
`endif
    .oLost(oLost));

`ifndef TRACK_DROP_COUNT_EN
  assign drop = 8'd0;
`endif

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one detector frame: strobe held len cycles, outputs captured at E+2 and E+3
  task automatic frame(input logic [10:0] r, input logic [10:0] c, input logic p, input int len);
    iRow = r;
    iCol = c;
    iPresent = p;
    iCoordValid = 1'b1;
    for (int i = 1; i <= len + 3; i++) begin
      tick();
      if (i == len) iCoordValid = 1'b0;
      if (i == 2) begin
        v2 = oValid; r2 = oRow; c2 = oCol; t2 = oTracking; l2 = oLost;
      end
      if (i == 3) begin
        v3 = oValid; l3 = oLost;
      end
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", oValid, 0);
    chk("rst_row", oRow, 0);
    chk("rst_track", oTracking, 0);
    chk("rst_lost", oLost, 0);
    iRST = 1'b1;
    tick(); tick();
    frame(100, 200, 1, 5);
    chk("f1_valid", v2, 0);
    chk("f1_track", t2, 0);
    frame(100, 200, 1, 5);
    chk("f2_valid", v2, 0);
    chk("f2_track", t2, 0);
    frame(100, 200, 1, 5);
    chk("f3_valid", v2, 1);
    chk("f3_row", r2, 100);
    chk("f3_col", c2, 200);
    chk("f3_track", t2, 1);
    chk("f3_pulse", v3, 0);
    frame(140, 200, 1, 2);
    chk("smooth_valid", v2, 1);
    chk("smooth_row", r2, 110);
    chk("smooth_col", c2, 200);
    frame(300, 200, 1, 2);
    chk("jump_valid", v2, 1);
    chk("jump_row", r2, 110);
    chk("jump_col", c2, 200);
    chk("jump_coast_track", t2, 1);
    frame(110, 200, 1, 2);
    chk("retrack_row", r2, 110);
    for (int m = 1; m <= 3; m++) begin
      frame(0, 0, 0, 2);
      chk($sformatf("miss%0d_valid", m), v2, 1);
      chk($sformatf("miss%0d_row", m), r2, 110);
      chk($sformatf("miss%0d_track", m), t2, 1);
      chk($sformatf("miss%0d_lost", m), l2, 0);
    end
    frame(0, 0, 0, 2);
    chk("miss4_valid", v2, 0);
    chk("miss4_track", t2, 0);
    chk("miss4_lost", l2, 1);
    chk("miss4_lost_pulse", l3, 0);
    frame(50, 60, 1, 2);
    frame(50, 60, 1, 2);
    chk("reacq_track", t2, 0);
    iReady = 1'b0;
    frame(50, 60, 1, 2);
    chk("hold_valid_a", v2, 1);
    frame(50, 60, 1, 2);
    chk("hold_valid_b", v3, 1);
    chk("hold_row", oRow, 50);
    chk("hold_col", oCol, 60);
`ifdef TRACK_DROP_COUNT_EN
    chk("drop_one", drop, 1);
`endif
    iReady = 1'b1;
    tick();
    chk("accept_clears", oValid, 0);
`ifdef TRACK_DROP_COUNT_EN
    dclr = 1'b1;
    tick();
    dclr = 1'b0;
    chk("drop_clr", drop, 0);
`endif
    iReady = 1'b0;
    frame(50, 60, 1, 2);
    chk("en_pre_valid", v2, 1);
    iEnable = 1'b0;
    iRow = 70;
    iCoordValid = 1'b1;
    tick();
    chk("dis_valid", oValid, 0);
    chk("dis_track", oTracking, 0);
    tick();
    chk("dis_nopub", oValid, 0);
    iCoordValid = 1'b0;
    tick();
    iEnable = 1'b1;
    iReady = 1'b1;
    tick(); tick();
    frame(479, 639, 1, 2);
    frame(479, 639, 1, 2);
    frame(479, 639, 1, 2);
    chk("edge_track", t2, 1);
    chk("edge_row", r2, 479);
    chk("edge_col", c2, 639);
    iEnable = 1'b0;
    tick();
    iEnable = 1'b1;
    tick(); tick();
    frame(10, 10, 1, 2);
    frame(10, 10, 1, 2);
    frame(500, 10, 1, 2);
    chk("oor_track", t2, 0);
    frame(10, 10, 1, 2);
    chk("oor_reacq_track", t2, 0);
    frame(10, 10, 1, 2);
    chk("acq2_track", t2, 0);
    chk("acq2_row_held", oRow, 479);
    iRST = 1'b0;
    #1;
    chk("arst_row", oRow, 0);
    chk("arst_col", oCol, 0);
    chk("arst_valid", oValid, 0);
    chk("arst_track", oTracking, 0);
    chk("arst_drop", drop, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
